// File: rtl/regbank_pkg.sv
// Shared constants and FSM state type for the register-bank read path.
package regbank_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned REG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        CAP  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/regbank_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Kept standalone so the write-port arbiter can reuse it.
module regbank_rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     Req,
    input  logic [PTR_W-1:0] Ptr,
    output logic             Found,
    output logic [PTR_W-1:0] Winner
);

    // Scan N slots starting at Ptr; the first hit wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        Found  = 1'b0;
        Winner = '0;
        idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PTR_W'((32'(Ptr) + i) % N);
            if (!Found && Req[idx]) begin
                Found  = 1'b1;
                Winner = idx;
            end
        end
    end

endmodule

// File: rtl/regbank_read_arbiter.sv
// Round-robin arbiter sharing the register bank's registered 16:1 read mux.
// One read every 3 cycles: grant/select, wait for the mux register, capture.
module regbank_read_arbiter
    import regbank_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = REG_ADDR_W,
    parameter int unsigned DATA_W  = REG_DATA_W
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ*ADDR_W-1:0] Addr,
    output logic [NUM_REQ-1:0]        Grant,
    output logic [ADDR_W-1:0]         Select,
    input  logic [DATA_W-1:0]         MuxData,
    output logic [DATA_W-1:0]         RData,
    output logic [NUM_REQ-1:0]        RValid,
    output logic                      Busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    rd_state_t        state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic             found;
    logic [PTR_W-1:0] pick;

    regbank_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .Req    (Req),
        .Ptr    (ptr),
        .Found  (found),
        .Winner (pick)
    );

    // Busy is a pure decode of the state register.
    always_comb begin
        Busy = (state != IDLE);
    end

    // Arbitration FSM with registered Grant/Select/RData/RValid and round-robin pointer.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            ptr    <= '0;
            win    <= '0;
            Grant  <= '0;
            RValid <= '0;
            Select <= '0;
            RData  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    RValid <= '0;
                    if (found) begin
                        // Addr is sampled only here; later changes cannot disturb the read.
                        Select <= Addr[pick*ADDR_W +: ADDR_W];
                        Grant  <= NUM_REQ'(1) << pick;
                        win    <= pick;
                        state  <= SEL;
                    end else begin
                        Grant <= '0;
                    end
                end
                SEL: begin
                    // Select held while the mux registers its output.
                    Grant <= '0;
                    state <= CAP;
                end
                CAP: begin
                    RData  <= MuxData;
                    RValid <= NUM_REQ'(1) << win;
                    ptr    <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
                    state  <= IDLE;
                end
                default: begin
                    Grant  <= '0;
                    RValid <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_read_arbiter.sv
// Bench for regbank_read_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_regbank_read_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    logic            Clock = 1'b0;
    logic            Reset = 1'b0;
    logic [N-1:0]    Req   = '0;
    logic [N*AW-1:0] Addr  = '0;
    logic [N-1:0]    Grant;
    logic [N-1:0]    RValid;
    logic [AW-1:0]   Select;
    logic [DW-1:0]   MuxData = '0;
    logic [DW-1:0]   RData;
    logic            Busy;

    logic [DW-1:0] regs [16];

    int checks   = 0;
    int failures = 0;

    regbank_read_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Req     (Req),
        .Addr    (Addr),
        .Grant   (Grant),
        .Select  (Select),
        .MuxData (MuxData),
        .RData   (RData),
        .RValid  (RValid),
        .Busy    (Busy)
    );

    always #5 Clock = ~Clock;

    // Register bank plus its registered 16:1 read mux.
    always @(posedge Clock) MuxData <= regs[Select];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        Addr[i*AW +: AW] = a;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        #1 Reset = 1'b0;
    endtask

    // Transaction-level model: a read occupies a 3-cycle slot; m_left counts
    // remaining slot cycles, m_ptr is the next requester to favour.
    int unsigned   m_ptr  = 0;
    int unsigned   m_left = 0;
    int unsigned   m_win  = 0;
    logic [N-1:0]  e_grant  = '0;
    logic [N-1:0]  e_rvalid = '0;
    logic [AW-1:0] e_select = '0;
    logic [DW-1:0] e_rdata  = '0;
    logic          e_busy   = 1'b0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_ptr = 0; m_left = 0; m_win = 0;
            e_grant = '0; e_rvalid = '0; e_select = '0; e_rdata = '0; e_busy = 1'b0;
        end else begin
            e_grant  = '0;
            e_rvalid = '0;
            if (m_left == 0) begin
                for (int k = 0; k < N; k++) begin
                    int unsigned idx;
                    idx = (m_ptr + k) % N;
                    if (m_left == 0 && Req[idx]) begin
                        m_win    = idx;
                        m_left   = 2;
                        e_grant  = N'(1) << idx;
                        e_select = Addr[idx*AW +: AW];
                    end
                end
            end else if (m_left == 2) begin
                m_left = 1;
            end else begin
                m_left   = 0;
                e_rdata  = regs[e_select];
                e_rvalid = N'(1) << m_win;
                m_ptr    = (m_win + 1) % N;
            end
            e_busy = (m_left != 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        if ($time > 20) begin
            chk("grant",   DW'(Grant),  DW'(e_grant));
            chk("rvalid",  DW'(RValid), DW'(e_rvalid));
            chk("select",  DW'(Select), DW'(e_select));
            chk("rdata",   RData,       e_rdata);
            chk("busy",    DW'(Busy),   DW'(e_busy));
            chk("grant_onehot0",  DW'($onehot0(Grant)),  32'd1);
            chk("rvalid_onehot0", DW'($onehot0(RValid)), 32'd1);
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[5] = 32'h0AAA_AAAA;
        regs[9] = ~regs[7];
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        #1 Reset = 1'b0;

        // Single read of r5 by requester 0.
        @(negedge Clock);
        #1 Req = 3'b001; set_addr(0, 4'd5);
        @(negedge Clock);
        chk("t1_grant", DW'(Grant), 32'h1);
        chk("t1_busy_a", DW'(Busy), 32'h1);
        #1 Req = '0;
        @(negedge Clock);
        chk("t1_grant_clr", DW'(Grant), 32'h0);
        chk("t1_busy_b", DW'(Busy), 32'h1);
        @(negedge Clock);
        chk("t1_rvalid", DW'(RValid), 32'h1);
        chk("t1_rdata", RData, 32'h0AAA_AAAA);
        chk("t1_busy_c", DW'(Busy), 32'h0);
        @(negedge Clock);
        chk("t1_rvalid_clr", DW'(RValid), 32'h0);

        // All three requesting after reset: served 0,1,2.
        do_reset();
        #1 Req = 3'b111; set_addr(0, 4'd1); set_addr(1, 4'd2); set_addr(2, 4'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            chk("t2_grant", DW'(Grant), DW'(N'(1) << k));
            @(negedge Clock);
            @(negedge Clock);
            chk("t2_rvalid", DW'(RValid), DW'(N'(1) << k));
            chk("t2_rdata", RData, regs[k+1]);
        end
        #1 Req = '0;

        // Fairness: requester 0 keeps asking, 2 joins after the first grant.
        do_reset();
        #1 Req = 3'b001; set_addr(0, 4'd4);
        @(negedge Clock);
        chk("t3_grant0", DW'(Grant), 32'h1);
        #1 Req = 3'b101; set_addr(2, 4'd6);
        @(negedge Clock);
        @(negedge Clock);
        @(negedge Clock);
        chk("t3_grant2", DW'(Grant), 32'h4);
        #1 Req = '0;
        @(negedge Clock);
        @(negedge Clock);
        chk("t3_rvalid", DW'(RValid), 32'h4);
        chk("t3_rdata", RData, regs[6]);

        // Address change after grant has no effect (pointer is 0 here).
        @(negedge Clock);
        #1 Req = 3'b010; set_addr(1, 4'd7);
        @(negedge Clock);
        chk("t4_grant", DW'(Grant), 32'h2);
        #1 Req = '0;
        @(negedge Clock);
        #1 set_addr(1, 4'd9);
        @(negedge Clock);
        chk("t4_rdata", RData, regs[7]);
        chk("t4_rvalid", DW'(RValid), 32'h2);

        // Reset mid-read (pointer is 2 beforehand).
        @(negedge Clock);
        #1 Req = 3'b001; set_addr(0, 4'd5);
        @(negedge Clock);
        chk("t5_grant", DW'(Grant), 32'h1);
        #1 Req = '0; Reset = 1'b1;
        #1;
        chk("t5_select_rst", DW'(Select), 32'h0);
        chk("t5_rdata_rst", RData, 32'h0);
        chk("t5_grant_rst", DW'(Grant), 32'h0);
        chk("t5_rvalid_rst", DW'(RValid), 32'h0);
        chk("t5_busy_rst", DW'(Busy), 32'h0);
        @(negedge Clock);
        #1 Reset = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            chk("t5_no_rvalid", DW'(RValid), 32'h0);
        end
        #1 Req = 3'b111;
        @(negedge Clock);
        chk("t5_first_grant", DW'(Grant), 32'h1);
        #1 Req = '0;
        repeat (3) @(negedge Clock);

        // Randomized traffic with occasional resets.
        repeat (1500) begin
            @(negedge Clock);
            #1;
            Reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                if (Req[i] && Grant[i]) Req[i] = ($urandom_range(0, 1) == 0);
                else if (!Req[i]) Req[i] = ($urandom_range(0, 9) < 3);
                else if ($urandom_range(0, 19) == 0) Req[i] = 1'b0;
                if ($urandom_range(0, 4) == 0) set_addr(i, AW'($urandom_range(0, 15)));
            end
        end
        @(negedge Clock);
        #1 Reset = 1'b0; Req = '0;
        repeat (5) @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_read_arbiter.md
# regbank_read_arbiter

Shares the register bank's single 16:1 read mux (`mux`: `Select` in, 32-bit `Output` out, registered on `Clock`) between several requesters, such as the operand-A fetch, operand-B fetch and store-data paths. The block does three things:
- It arbitrates round-robin among pending requests.
- It drives the mux `Select` for the winner and captures the mux `Output`.
- It returns the data with a per-requester valid pulse.

It sits between the CPU control/decode logic and the register bank.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `ADDR_W`, 4: register index width. This must match the mux `Select` width.
- `DATA_W`, 32: register data width.

Ports:
- `Clock`, in, 1: single clock. All state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Req`, in, `NUM_REQ`: per-requester read request. Level-sensitive; held until `Grant`.
- `Addr`, in, `NUM_REQ*ADDR_W`: register index for requester i, in bits `[i*ADDR_W +: ADDR_W]`.
- `Grant`, out, `NUM_REQ`: one-hot, one-cycle pulse when the request is accepted.
- `Select`, out, `ADDR_W`: drives the mux `Select`.
- `MuxData`, in, `DATA_W`: the mux `Output`.
- `RData`, out, `DATA_W`: captured read data. Shared by all requesters.
- `RValid`, out, `NUM_REQ`: one-hot, one-cycle pulse. `RData` is valid for requester i.
- `Busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, SEL, CAP.
- **IDLE:**
  - If no `Req` bit is set, stay in IDLE.
  - Otherwise pick the winner w: the first set `Req` bit searching upward, with wrap-around, from pointer `Ptr`.
  - On the edge: `Select`<=`Addr[w]`, `Grant`<=onehot(w), latch w, go to SEL.
- **SEL:**
  - `Grant`<=0. `Select` is held.
  - Go to CAP. This cycle covers the mux's registered output.
- **CAP:**
  - `RData`<=`MuxData`, `RValid`<=onehot(w), `Ptr`<=(w+1) mod `NUM_REQ`.
  - Go to IDLE.
- `RValid` clears on the following edge.
- `Select` and `RData` hold their last values in IDLE.
- `Addr` is sampled only at grant. Later changes to `Addr` or `Req` do not affect the in-flight read.
- A `Req` withdrawn before it is granted is simply not served.
- If a requester keeps `Req` high past `Grant`, the block treats it as a new request. That request is eligible at the next IDLE evaluation, with round-robin order applied.
- Simultaneous requests are served in pointer order. The pointer advances past the last winner, so the starvation bound is `NUM_REQ`-1 other grants.
- `Busy` = (state != IDLE). It is decoded from state.
- Reset values: state IDLE, `Ptr`=0, and `Grant`, `RValid`, `Select`, `RData` all 0.

## Timing
- The request is seen at edge E0.
- `Grant` is high in the cycle after E0. `Select` is valid from E0.
- The mux registers the data at E1.
- `RData` and `RValid` update at E2 and are high in the cycle after E2.
- Latency is 3 edges from the first sampling of `Req` to `RValid`.
- Throughput is one read per 3 cycles. The next arbitration happens at E3.
- Reset asserted mid-operation forces every output to 0 and the state to IDLE immediately, without waiting for a clock edge. The in-flight read is dropped and no `RValid` is produced. After `Reset` deasserts, arbitration restarts from requester 0.
- `Grant` and `RValid` are never both high for different requesters in the same cycle. Each is at most one-hot.

## Structure
- Package `regbank_pkg` holds `REG_ADDR_W`=4, `REG_DATA_W`=32, and the FSM state typedef (IDLE/SEL/CAP).
- Sub-module `regbank_rr_pick` is a purely combinational round-robin picker.
  - Inputs: `Req`, `Ptr`.
  - Outputs: `Found`, winner index.
  - It is reusable by the future write-port arbiter.
- The top level holds the FSM, `Ptr`, the `Select`/`RData` registers and the output pulses.

## Test plan
1. **Single read:**
   - Stimulus: `r5`=32'h0AAA_AAAA; `Req`=3'b001 with `Addr[0]`=5.
   - Required: `Grant`=001 one cycle later; `RData`=32'h0AAA_AAAA with `RValid`=001 at +3 edges; `Busy` high for exactly 2 cycles.
2. **All three requesting after reset:**
   - Stimulus: `Req`=3'b111 held, with `Addr`={3,2,1} for requesters 2,1,0.
   - Required: grants in order 0,1,2 at 3-cycle spacing; `RData` equals `r1`, `r2`, `r3` in turn.
3. **Fairness:**
   - Stimulus: requester 0 holds `Req` continuously; requester 2 asserts after the first grant.
   - Required: the next grant goes to 2, not 0.
4. **Address change after grant:**
   - Stimulus: change `Addr[1]` from 7 to 9 the cycle after `Grant`=010.
   - Required: `RData` = `r7`.
5. **Reset mid-read:**
   - Stimulus: assert `Reset` in SEL.
   - Required: `Select`, `RData`, `Grant`, `RValid` = 0 at once; no `RValid` after release; the first grant afterwards goes to requester 0.
